fetch_unit: RTL

- Instruction fetch front end that produces the instruction stream consumed by the IF/ID pipeline register and the decode stage.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel with variable response latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects from EX (branches/jumps) and discards stale in-flight responses.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, PC step and fetch buffer entry.
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;
   localparam int PC_STEP = 4;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered fetch: the instruction word together with the PC it came from.
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries. The head entry is read
// straight out of the array, so a pushed word is visible one cycle after the push.
// Flush empties the buffer and wins over a same-cycle push or pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     wr_data,
   output fetch_entry_t     rd_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   // Pointers carry one extra wrap bit so that full and empty are distinguishable.
   logic [CNT_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign count     = r_wr_ptr - r_rd_ptr;
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign w_do_push = push && !flush;
   assign w_do_pop  = pop && !flush && !empty;
   assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

   // Storage array: written on push only, no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointer update: flush rewinds both pointers, otherwise advance on push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      end
   end

   // The front end's credit scheme must never push into a full buffer.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (reset) !(push && full && !flush));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order word fetches to instruction memory,
// buffers returned words with their PCs and hands them to decode. EX redirects
// flush the buffer and discard every response still in flight.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 4,
   parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [XLEN-1:0]    instr_pc,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc
);
   localparam logic [CNT_W:0]   CREDITS = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0]  STEP    = XLEN'(PC_STEP);

   logic [XLEN-1:0]  r_fetch_pc;
   logic [XLEN-1:0]  r_resp_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;
   logic             r_started;

   logic [XLEN-1:0]  w_redirect_target;
   logic [CNT_W:0]   w_credit_used;
   logic             w_req_fire;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_fifo_count;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   fetch_entry_t     w_push_entry;
   fetch_entry_t     w_head;

   assign w_redirect_target = redirect_pc & ~XLEN'(3);

   // A request may only go out when every in-flight word is guaranteed a slot.
   assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
   assign imem_req_valid = r_started && !redirect_valid && (w_credit_used < CREDITS);
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // Responses are kept only when nothing is pending to be dropped and no redirect is happening now.
   assign w_push       = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_push_entry = '{pc: r_resp_pc, instr: imem_resp_data};
   assign w_pop        = instr_valid && instr_ready;

   assign instr_valid = !w_fifo_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (w_push),
      .pop     (w_pop),
      .flush   (redirect_valid),
      .wr_data (w_push_entry),
      .rd_data (w_head),
      .count   (w_fifo_count),
      .empty   (w_fifo_empty),
      .full    (w_fifo_full)
   );

   // PC, in-flight and drop bookkeeping; a redirect reloads both PCs and marks all in-flight words stale.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_started     <= 1'b0;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_started     <= 1'b1;
         r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_resp_valid);
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
            r_resp_pc  <= w_redirect_target;
            r_drop_cnt <= r_outstanding - CNT_W'(imem_resp_valid);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + STEP;
            if (w_push)     r_resp_pc  <= r_resp_pc + STEP;
            if (imem_resp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
         end
      end
   end

   // Counter sanity: in-flight never exceeds the credit pool, stale count never exceeds in-flight.
   a_outstanding_bound : assert property (@(posedge clk) disable iff (reset) r_outstanding <= CNT_W'(FIFO_DEPTH));
   a_drop_bound        : assert property (@(posedge clk) disable iff (reset) r_drop_cnt <= r_outstanding);

endmodule
